// File: rtl/axilm_wr_arb.sv
// Round-robin arbiter serialising NUM_REQ local write ports onto one AXI-Lite write master.
// Optional watchdog in WAIT_DONE: define AXILM_WR_ARB_TIMEOUT_EN.
module axilm_wr_arb #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [NUM_REQ-1:0]         REQ_ENA,
  input  logic [4*NUM_REQ-1:0]       REQ_WSTB,
  input  logic [32*NUM_REQ-1:0]      REQ_ADDR,
  input  logic [32*NUM_REQ-1:0]      REQ_WDATA,
  output logic [NUM_REQ-1:0]         REQ_ACK,
  output logic [1:0]                 REQ_BRESP,
  output logic                       M_ENA,
  output logic [3:0]                 M_WSTB,
  output logic [31:0]                M_ADDR,
  output logic [31:0]                M_WDATA,
  input  logic                       M_DONE,
  input  logic [1:0]                 M_BRESP,
  output logic                       BUSY,
  output logic [$clog2(NUM_REQ)-1:0] GRANT_ID
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("axilm_wr_arb: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic [3:0]    win_wstb;

`ifdef AXILM_WR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;
`endif

  // First active requester searching upward from ptr+1, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && REQ_ENA[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_wstb = REQ_WSTB[4*win +: 4];

  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      REQ_ACK   <= '0;
      REQ_BRESP <= 2'b00;
      M_ENA     <= 1'b0;
      M_WSTB    <= '0;
      M_ADDR    <= '0;
      M_WDATA   <= '0;
      BUSY      <= 1'b0;
      GRANT_ID  <= '0;
`ifdef AXILM_WR_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      M_ENA   <= 1'b0;
      REQ_ACK <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            GRANT_ID <= win;
            M_WSTB   <= win_wstb;
            M_ADDR   <= REQ_ADDR[32*win +: 32];
            M_WDATA  <= REQ_WDATA[32*win +: 32];
            BUSY     <= 1'b1;
            if (win_wstb != 4'h0) begin
              state <= S_ISSUE;
              M_ENA <= 1'b1;
            end else begin
              // Nothing to write: complete locally with OKAY
              state        <= S_RESP;
              REQ_BRESP    <= 2'b00;
              REQ_ACK[win] <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef AXILM_WR_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (M_DONE) begin
            state             <= S_RESP;
            REQ_BRESP         <= M_BRESP;
            REQ_ACK[GRANT_ID] <= 1'b1;
          end
`ifdef AXILM_WR_ARB_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state             <= S_RESP;
            REQ_BRESP         <= 2'b10;
            REQ_ACK[GRANT_ID] <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          ptr   <= GRANT_ID;
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
